// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sequencer: steps a gate through every input vector, waits a settle
// time per vector, and compares the gate output against an expected table latched at start.
module gate_sweep_ctrl #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expect_vec,
    output logic [N_IN-1:0]        dut_a,
    input  logic                   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_fail,
    output logic                   first_fail_vld
);

    localparam int unsigned NumVec = 1 << N_IN;
    localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StFin} state_e;

    state_e                 state_q, state_d;
    logic [N_IN-1:0]        vec_q, vec_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NumVec-1:0]      exp_q, exp_d;
    logic [N_IN:0]          err_q, err_d;
    logic [N_IN-1:0]        ff_q, ff_d;
    logic                   ffv_q, ffv_d;
    logic                   pass_q, pass_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mismatch;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        err_d    = err_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    vec_d   = '0;
                    cnt_d   = '0;
                    exp_d   = expect_vec;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(SETTLE - 1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Case inequality so an X or Z on the gate output is flagged as a failure.
                mismatch = (dut_y !== exp_q[vec_q]);
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                end
                if (vec_q == N_IN'(NumVec - 1)) begin
                    state_d = StFin;
                    vec_d   = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = StWait;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StWait) || (state_d == StCheck);
        done_d = (state_d == StFin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dut_a          = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;

endmodule
